ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares the single-port system RAM between the rgpu video fetch port and the CPU data port. The arbiter grants one requester per cycle, muxes address/write data onto the RAM, and routes the 1-cycle-latency read data back with a per-requester valid strobe. The GPU has fixed priority because it is real-time scan-out. A starvation counter guarantees the CPU a slot after a bounded wait.

Parameters:
ADDR_W, 16, address width of RAM and both requesters
DATA_W, 16, data word width
CPU_MAX_WAIT, 8, consecutive lost conflict cycles after which the CPU is forced a grant (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
gpuReq  in  1  GPU read request, held until granted
gpuAddr  in  ADDR_W  GPU read address
gpuGnt  out  1  GPU request accepted this cycle (combinational)
gpuRData  out  DATA_W  read data to GPU
gpuValid  out  1  gpuRData valid (cycle after gpuGnt)
cpuReq  in  1  CPU request, held until granted
cpuWE  in  1  1 = write, 0 = read
cpuAddr  in  ADDR_W  CPU address
cpuWData  in  DATA_W  CPU write data
cpuGnt  out  1  CPU request accepted this cycle (combinational)
cpuRData  out  DATA_W  read data to CPU
cpuValid  out  1  cpuRData valid (cycle after read grant; never for writes)
memAddr  out  ADDR_W  RAM address
memWData  out  DATA_W  RAM write data
memWE  out  1  RAM write enable
memRE  out  1  RAM read enable
memRData  in  DATA_W  RAM read data, registered in RAM, valid 1 cycle after memRE

Behaviour:
- While rst low, all state is cleared asynchronously: gpuValid = cpuValid = 0, owner = NONE, waitCnt = 0. Grants, memRE and memWE are forced to 0. memAddr and memWData are 0.
- Grant decision (combinational, each cycle):
  - Only gpuReq: GPU wins.
  - Only cpuReq: CPU wins.
  - Both requesting: GPU wins unless waitCnt == CPU_MAX_WAIT, in which case CPU wins.
  - Neither requesting: no grant, memRE = memWE = 0.
- Winner drives the RAM:
  - GPU: memAddr = gpuAddr, memRE = 1.
  - CPU: memAddr = cpuAddr, memWData = cpuWData, memWE = cpuWE, memRE = !cpuWE.
  - With no grant, memAddr and memWData hold their last driven values; this is don't-care for the RAM.
- Read return: owner register records the read owner (GPU, CPU or NONE) at each edge.
  - Next cycle, the owner's Valid = 1 and its RData = memRData.
  - The non-owner's Valid = 0 and its RData holds its last value.
  - A CPU write records NONE.
- waitCnt (0..CPU_MAX_WAIT, ADDR-independent width ceil(log2(CPU_MAX_WAIT+1))):
  - Increments on any cycle where cpuReq = 1 and the GPU is granted.
  - Clears on a CPU grant.
  - Holds when cpuReq = 0.
  - Saturates; it never wraps.
- Back-to-back grants to the same or alternating requesters are allowed every cycle; throughput is 1 access/cycle.
- A requester dropping req without a grant is legal; it must not cause a spurious Valid.
- Reset asserted mid-access: any pending Valid is lost and not re-issued after reset.

Optional Feature:
ARB_STATS_EN:
- When defined, adds outputs statGpu, statCpu and statForced (16 bit each).
  - statGpu counts GPU grants.
  - statCpu counts CPU grants.
  - statForced counts grants forced by waitCnt.
  - All three clear on reset and wrap at 16'hFFFF to 0.
- When not defined, these ports and counters do not exist, and grant behaviour is identical.

Decomposition:
- Package rcpu_mem_pkg holds the owner encoding (OWN_NONE = 2'b00, OWN_GPU = 2'b01, OWN_CPU = 2'b10) and the default ADDR_W/DATA_W constants shared with rgpu and RAM.
- One sub-module, arb_starve_counter, implements the saturating waitCnt with inc/clr/at-limit outputs.

Test Plan:
- Reset held low with gpuReq = cpuReq = 1 -> all grants, valids, memRE and memWE are 0. Release -> GPU is granted on the first edge.
- GPU only, gpuAddr = 16'h2000, RAM[16'h2000] = 16'hBEEF -> gpuGnt same cycle; gpuValid = 1 with gpuRData = 16'hBEEF exactly one cycle later.
- CPU write 16'h1234 to 16'h1000, then CPU read of 16'h1000 -> memWE = 1 with no cpuValid on the write; cpuValid = 1 with cpuRData = 16'h1234 on the read return.
- gpuReq and cpuReq held high continuously, CPU_MAX_WAIT = 8 -> pattern is 8 GPU grants then 1 CPU grant, repeating. waitCnt never exceeds 8.
- Alternating GPU/CPU reads at 16'h0000/16'h0001 every cycle -> each returned word goes to the correct requester, with no valid overlap.
- With ARB_STATS_EN, 20 cycles of dual request (CPU_MAX_WAIT = 8) -> statGpu = 18, statCpu = 2, statForced = 2.

Source files
------------

// File: rtl/rcpu_mem_pkg.sv
// Shared definitions for the system RAM path: read-owner encoding and default bus widths.
package rcpu_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_GPU  = 2'b01,
        OWN_CPU  = 2'b10
    } owner_t;

    // Bits needed to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating CPU wait counter: counts lost conflict cycles, flags when the CPU must be forced in.
module arb_starve_counter
    import rcpu_mem_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = cnt_width(MAX);

    logic [W-1:0] cnt;

    assign at_limit = (cnt == W'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// GPU/CPU arbiter for the single-port system RAM; GPU has fixed priority, CPU is
// forced in after CPU_MAX_WAIT lost cycles. Define ARB_STATS_EN for grant statistics.
module ram_arbiter
    import rcpu_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gpuReq,
    input  logic [ADDR_W-1:0] gpuAddr,
    output logic              gpuGnt,
    output logic [DATA_W-1:0] gpuRData,
    output logic              gpuValid,
    input  logic              cpuReq,
    input  logic              cpuWE,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic              cpuGnt,
    output logic [DATA_W-1:0] cpuRData,
    output logic              cpuValid,
`ifdef ARB_STATS_EN
    output logic [15:0]       statGpu,
    output logic [15:0]       statCpu,
    output logic [15:0]       statForced,
`endif
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              memWE,
    output logic              memRE,
    input  logic [DATA_W-1:0] memRData
);

    logic              at_limit;
    logic              gpu_win;
    logic              cpu_win;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] gpu_hold;
    logic [DATA_W-1:0] cpu_hold;

    // rst gates the grants so nothing reaches the RAM while reset is asserted.
    assign gpu_win = rst && gpuReq && !(cpuReq && at_limit);
    assign cpu_win = rst && cpuReq && !gpu_win;

    assign gpuGnt   = gpu_win;
    assign cpuGnt   = cpu_win;
    assign memRE    = gpu_win || (cpu_win && !cpuWE);
    assign memWE    = cpu_win && cpuWE;
    assign memAddr  = gpu_win ? gpuAddr : (cpu_win ? cpuAddr : addr_q);
    assign memWData = cpu_win ? cpuWData : wdata_q;

    assign gpuValid = (owner == OWN_GPU);
    assign cpuValid = (owner == OWN_CPU);
    assign gpuRData = gpuValid ? memRData : gpu_hold;
    assign cpuRData = cpuValid ? memRData : cpu_hold;

    arb_starve_counter #(
        .MAX (CPU_MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (cpuReq && gpu_win),
        .clr      (cpu_win),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= OWN_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            gpu_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (gpu_win)
                owner <= OWN_GPU;
            else if (cpu_win && !cpuWE)
                owner <= OWN_CPU;
            else
                owner <= OWN_NONE;
            addr_q  <= memAddr;
            wdata_q <= memWData;
            // Latch the returned word so it stays visible after Valid drops.
            if (owner == OWN_GPU) gpu_hold <= memRData;
            if (owner == OWN_CPU) cpu_hold <= memRData;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statGpu    <= '0;
            statCpu    <= '0;
            statForced <= '0;
        end else begin
            if (gpu_win) statGpu <= statGpu + 16'd1;
            if (cpu_win) statCpu <= statCpu + 16'd1;
            // A CPU grant while the GPU is also asking can only come from the limit.
            if (cpu_win && gpuReq) statForced <= statForced + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, priority/starvation reference model.
module tb_ram_arbiter;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gpuReq = 1'b0;
    logic [15:0] gpuAddr = '0;
    logic        gpuGnt;
    logic [15:0] gpuRData;
    logic        gpuValid;
    logic        cpuReq = 1'b0;
    logic        cpuWE = 1'b0;
    logic [15:0] cpuAddr = '0;
    logic [15:0] cpuWData = '0;
    logic        cpuGnt;
    logic [15:0] cpuRData;
    logic        cpuValid;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic        memWE;
    logic        memRE;
    logic [15:0] memRData = '0;
`ifdef ARB_STATS_EN
    logic [15:0] statGpu, statCpu, statForced;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Environment RAM (registered read) and the model's own shadow copy.
    logic [15:0] ram    [0:65535];
    logic [15:0] shadow [0:65535];

    // Reference model state.
    int          exp_wait;
    bit          pend_g, pend_c;
    logic [15:0] pend_gd, pend_cd, last_gd, last_cd;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .gpuReq(gpuReq), .gpuAddr(gpuAddr), .gpuGnt(gpuGnt),
        .gpuRData(gpuRData), .gpuValid(gpuValid),
        .cpuReq(cpuReq), .cpuWE(cpuWE), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuGnt(cpuGnt), .cpuRData(cpuRData), .cpuValid(cpuValid),
`ifdef ARB_STATS_EN
        .statGpu(statGpu), .statCpu(statCpu), .statForced(statForced),
`endif
        .memAddr(memAddr), .memWData(memWData), .memWE(memWE), .memRE(memRE),
        .memRData(memRData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memRE) memRData <= ram[memAddr];
        if (memWE) ram[memAddr] = memWData;
    end

    function automatic void model_grant(input bit gr, input bit cr, output bit eg, output bit ec);
        eg = gr && !(cr && exp_wait == MAXW);
        ec = cr && !eg;
    endfunction

    function automatic void model_reset();
        exp_wait = 0;
        pend_g = 0; pend_c = 0;
        pend_gd = '0; pend_cd = '0; last_gd = '0; last_cd = '0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        bit eg, ec;
        model_grant(gpuReq, cpuReq, eg, ec);
        if (pend_g) last_gd = pend_gd;
        if (pend_c) last_cd = pend_cd;
        pend_g = eg;
        if (eg) pend_gd = shadow[gpuAddr];
        pend_c = ec && !cpuWE;
        if (pend_c) pend_cd = shadow[cpuAddr];
        if (ec && cpuWE) shadow[cpuAddr] = cpuWData;
        if (ec) exp_wait = 0;
        else if (eg && cpuReq && exp_wait < MAXW) exp_wait++;
    endfunction

    task automatic drive(input bit gr, input logic [15:0] ga, input bit cr, input bit we,
                         input logic [15:0] ca, input logic [15:0] wd);
        gpuReq = gr; gpuAddr = ga; cpuReq = cr; cpuWE = we; cpuAddr = ca; cpuWData = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 16'h0010, 1, 0, 16'h0011, 16'h0);
        @(negedge clk);
        n_cmp++;
        if ({gpuGnt, cpuGnt, memRE, memWE} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {gpuGnt, cpuGnt, memRE, memWE});
        end
        n_cmp++;
        if ({gpuValid, cpuValid} !== 2'b0 || memAddr !== 16'h0 || memWData !== 16'h0) begin
            n_bad++; $display("FAIL reset_state: valid %b addr %h wdata %h want 0", {gpuValid, cpuValid}, memAddr, memWData);
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (gpuGnt !== 1'b1 || cpuGnt !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: gnt g%b c%b want g1 c0", gpuGnt, cpuGnt);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_gpu_read();
        drive(1, 16'h2000, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (gpuGnt !== 1'b1 || memRE !== 1'b1 || memAddr !== 16'h2000) begin
            n_bad++; $display("FAIL gpu_grant: gnt %b re %b addr %h want 1 1 2000", gpuGnt, memRE, memAddr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (gpuValid !== 1'b1 || gpuRData !== 16'hBEEF || cpuValid !== 1'b0) begin
            n_bad++; $display("FAIL gpu_return: valid %b data %h cpuValid %b want 1 beef 0", gpuValid, gpuRData, cpuValid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (gpuValid !== 1'b0 || gpuRData !== 16'hBEEF) begin
            n_bad++; $display("FAIL gpu_hold: valid %b data %h want 0 beef", gpuValid, gpuRData);
        end
    endtask

    task automatic test_cpu_write_read();
        drive(0, 0, 1, 1, 16'h1000, 16'h1234);
        @(negedge clk);
        n_cmp++;
        if (cpuGnt !== 1'b1 || memWE !== 1'b1 || memRE !== 1'b0 || memWData !== 16'h1234 || memAddr !== 16'h1000) begin
            n_bad++; $display("FAIL cpu_write: gnt %b we %b re %b addr %h wd %h", cpuGnt, memWE, memRE, memAddr, memWData);
        end
        tick();
        drive(0, 0, 1, 0, 16'h1000, 16'h0);
        @(negedge clk);
        n_cmp++;
        if (cpuValid !== 1'b0 || memRE !== 1'b1 || memWE !== 1'b0) begin
            n_bad++; $display("FAIL cpu_write_novalid: valid %b re %b we %b want 0 1 0", cpuValid, memRE, memWE);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (cpuValid !== 1'b1 || cpuRData !== 16'h1234 || gpuValid !== 1'b0) begin
            n_bad++; $display("FAIL cpu_read: valid %b data %h want 1 1234", cpuValid, cpuRData);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit eg, ec;
        int gcnt = 0, ccnt = 0, bad_pat = 0;
`ifdef ARB_STATS_EN
        logic [15:0] s_g, s_c, s_f;
        @(negedge clk);
        s_g = statGpu; s_c = statCpu; s_f = statForced;
`endif
        for (int i = 0; i < 27; i++) begin
            drive(1, 16'($urandom_range(0, 63)), 1, 0, 16'($urandom_range(0, 63)), 0);
            @(negedge clk);
            model_grant(1, 1, eg, ec);
            if (gpuGnt !== eg || cpuGnt !== ec) bad_pat++;
            // Spec pattern: CPU gets exactly every ninth slot.
            if (cpuGnt !== ((i % 9) == 8)) bad_pat++;
            if (i < 20) begin
                gcnt += int'(gpuGnt); ccnt += int'(cpuGnt);
            end
`ifdef ARB_STATS_EN
            if (i == 20) begin
                n_cmp++;
                if (16'(statGpu - s_g) !== 16'd18 || 16'(statCpu - s_c) !== 16'd2 || 16'(statForced - s_f) !== 16'd2) begin
                    n_bad++; $display("FAIL stats: gpu %0d cpu %0d forced %0d want 18 2 2",
                                      16'(statGpu - s_g), 16'(statCpu - s_c), 16'(statForced - s_f));
                end
            end
`endif
            tick();
        end
        n_cmp++;
        if (bad_pat != 0) begin
            n_bad++; $display("FAIL starve_pattern: %0d bad cycles want 0", bad_pat);
        end
        n_cmp++;
        if (gcnt != 18 || ccnt != 2) begin
            n_bad++; $display("FAIL starve_counts: gpu %0d cpu %0d want 18 2", gcnt, ccnt);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_alternating();
        int errs = 0, overlap = 0;
        for (int i = 0; i < 14; i++) begin
            if (i % 2 == 0) drive(1, 16'h0000, 0, 0, 0, 0);
            else            drive(0, 0, 1, 0, 16'h0001, 0);
            @(negedge clk);
            if (gpuValid && cpuValid) overlap++;
            if (gpuValid !== pend_g || cpuValid !== pend_c) errs++;
            if (pend_g && gpuRData !== pend_gd) errs++;
            if (pend_c && cpuRData !== pend_cd) errs++;
            tick();
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++; $display("FAIL alternating: %0d return errors want 0", errs);
        end
        n_cmp++;
        if (overlap != 0) begin
            n_bad++; $display("FAIL alt_overlap: %0d overlapping valids want 0", overlap);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        bit eg, ec;
        int e_gnt = 0, e_mem = 0, e_ret = 0;
        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 63)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  16'($urandom_range(0, 63)), 16'($urandom));
            @(negedge clk);
            model_grant(gpuReq, cpuReq, eg, ec);
            if (gpuGnt !== eg || cpuGnt !== ec) e_gnt++;
            if (memRE !== (eg || (ec && !cpuWE)) || memWE !== (ec && cpuWE)) e_mem++;
            if (eg && memAddr !== gpuAddr) e_mem++;
            if (ec && (memAddr !== cpuAddr || memWData !== cpuWData)) e_mem++;
            if (gpuValid !== pend_g || cpuValid !== pend_c) e_ret++;
            if (gpuRData !== (pend_g ? pend_gd : last_gd)) e_ret++;
            if (cpuRData !== (pend_c ? pend_cd : last_cd)) e_ret++;
            tick();
        end
        n_cmp++;
        if (e_gnt != 0) begin n_bad++; $display("FAIL rand_grant: %0d errors want 0", e_gnt); end
        n_cmp++;
        if (e_mem != 0) begin n_bad++; $display("FAIL rand_mem: %0d errors want 0", e_mem); end
        n_cmp++;
        if (e_ret != 0) begin n_bad++; $display("FAIL rand_return: %0d errors want 0", e_ret); end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 16'h0005, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (gpuValid !== 1'b0 || cpuValid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: valid g%b c%b want 0 0", gpuValid, cpuValid);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tick();
        @(negedge clk);
        n_cmp++;
        if (gpuValid !== 1'b0 || cpuValid !== 1'b0 || gpuRData !== 16'h0) begin
            n_bad++; $display("FAIL reset_reissue: valid g%b c%b data %h want 0 0 0", gpuValid, cpuValid, gpuRData);
        end
        tick();
    endtask

    initial begin
        for (int a = 0; a < 64; a++) begin
            ram[a] = 16'($urandom);
            shadow[a] = ram[a];
        end
        ram[16'h2000] = 16'hBEEF;
        shadow[16'h2000] = 16'hBEEF;
        model_reset();
        test_reset();
        test_gpu_read();
        test_cpu_write_read();
        test_starvation();
        test_alternating();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
